// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU BIST state encoding and comparator flag indices
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } bist_state_t;

    localparam int FLAG_E = 2;
    localparam int FLAG_G = 1;
    localparam int FLAG_L = 0;

endpackage

// File: rtl/comp_golden.sv
// rtl/comp_golden.sv - combinational {E,G,L} reference for an unsigned magnitude compare
module comp_golden
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [2:0]       flags
);

    always_comb begin
        flags         = '0;
        flags[FLAG_E] = (a == b);
        flags[FLAG_G] = (a > b);
        flags[FLAG_L] = (a < b);
    end

endmodule

// File: rtl/comp_bist.sv
// rtl/comp_bist.sv - exhaustive sweep BIST controller for the magnitude comparator
module comp_bist
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    input  logic             E,
    input  logic             G,
    input  logic             L,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [2:0]       fail_flags
);

    localparam int VW = 2 * WIDTH;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);

    bist_state_t      state, state_nxt;
    logic [VW-1:0]    vec, vec_nxt;
    logic [SW-1:0]    settle_cnt, settle_nxt;
    logic [WIDTH-1:0] a_nxt, b_nxt, fail_a_nxt, fail_b_nxt;
    logic [CNT_W-1:0] err_nxt;
    logic [2:0]       fail_flags_nxt, golden, observed;
    logic             busy_nxt, done_nxt, pass_nxt, fail_valid_nxt, mismatch;

    comp_golden #(.WIDTH(WIDTH)) u_golden (
        .a     (A),
        .b     (B),
        .flags (golden)
    );

    assign observed = {E, G, L};
    assign mismatch = (observed != golden);

    always_comb begin
        state_nxt      = state;
        vec_nxt        = vec;
        settle_nxt     = settle_cnt;
        a_nxt          = A;
        b_nxt          = B;
        busy_nxt       = busy;
        done_nxt       = done;
        pass_nxt       = pass;
        err_nxt        = err_cnt;
        fail_valid_nxt = fail_valid;
        fail_a_nxt     = fail_a;
        fail_b_nxt     = fail_b;
        fail_flags_nxt = fail_flags;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt      = WAIT;
                    a_nxt          = '0;
                    b_nxt          = '0;
                    vec_nxt        = VW'(1);
                    settle_nxt     = SETTLE_LOAD;
                    busy_nxt       = 1'b1;
                    done_nxt       = 1'b0;
                    pass_nxt       = 1'b0;
                    err_nxt        = '0;
                    fail_valid_nxt = 1'b0;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b0;
                end else if (settle_cnt == '0) begin
                    state_nxt = CHECK;
                end else begin
                    settle_nxt = settle_cnt - 1'b1;
                end
            end
            CHECK: begin
                if (abort) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b0;
                end else begin
                    if (mismatch) begin
                        err_nxt = (err_cnt == '1) ? err_cnt : err_cnt + 1'b1;
                        if (!fail_valid) begin
                            fail_valid_nxt = 1'b1;
                            fail_a_nxt     = A;
                            fail_b_nxt     = B;
                            fail_flags_nxt = observed;
                        end
                    end
                    // The all-ones pair is the final vector; its verdict includes this cycle's result.
                    if (&{A, B}) begin
                        state_nxt = DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        pass_nxt  = (err_nxt == '0);
                    end else begin
                        state_nxt      = WAIT;
                        {a_nxt, b_nxt} = vec;
                        vec_nxt        = vec + 1'b1;
                        settle_nxt     = SETTLE_LOAD;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= '0;
            settle_cnt <= '0;
            A          <= '0;
            B          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_flags <= '0;
        end else begin
            state      <= state_nxt;
            vec        <= vec_nxt;
            settle_cnt <= settle_nxt;
            A          <= a_nxt;
            B          <= b_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            pass       <= pass_nxt;
            err_cnt    <= err_nxt;
            fail_valid <= fail_valid_nxt;
            fail_a     <= fail_a_nxt;
            fail_b     <= fail_b_nxt;
            fail_flags <= fail_flags_nxt;
        end
    end

endmodule

// File: tb/tb_comp_bist.sv
// tb/tb_comp_bist.sv - scoreboard bench for comp_bist with faulty comparator models
module tb_comp_bist;

    localparam int W  = 4;
    localparam int CW = 16;

    typedef struct {
        int         cycles;
        int         err;
        logic       fv;
        int         fa;
        int         fb;
        logic [2:0] ff;
        logic       pass;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start_r, abort_r;
    int   sel, mode;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    logic          start0, abort0, start1, abort1;
    logic [W-1:0]  a0, b0, a1, b1, fa0, fb0, fa1, fb1;
    logic          e0, g0, l0, e1, g1, l1;
    logic          busy0, done0, pass0, fv0, busy1, done1, pass1, fv1;
    logic [CW-1:0] err0, err1;
    logic [2:0]    ff0, ff1;

    logic          o_busy, o_done, o_pass, o_fv;
    logic [W-1:0]  o_a, o_b, o_fa, o_fb;
    logic [CW-1:0] o_err;
    logic [2:0]    o_ff;

    assign start0 = start_r && (sel == 0);
    assign abort0 = abort_r && (sel == 0);
    assign start1 = start_r && (sel == 1);
    assign abort1 = abort_r && (sel == 1);

    // mode 0 correct, 1 G/L swapped, 2 E stuck at 0, 3 E forced high at A=5,B=10
    function automatic logic [2:0] cmp_model(input int md, input int a, input int b);
        logic e, g, l;
        e = (a == b);
        g = (a > b);
        l = (a < b);
        case (md)
            1: begin g = (a < b); l = (a > b); end
            2: e = 1'b0;
            3: if (a == 5 && b == 10) e = 1'b1;
            default: ;
        endcase
        return {e, g, l};
    endfunction

    assign {e0, g0, l0} = cmp_model(mode, int'(a0), int'(b0));
    assign {e1, g1, l1} = cmp_model(mode, int'(a1), int'(b1));

    comp_bist #(.WIDTH(W), .SETTLE(1), .CNT_W(CW)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .A(a0), .B(b0), .E(e0), .G(g0), .L(l0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .fail_valid(fv0), .fail_a(fa0), .fail_b(fb0), .fail_flags(ff0)
    );

    comp_bist #(.WIDTH(W), .SETTLE(3), .CNT_W(CW)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .A(a1), .B(b1), .E(e1), .G(g1), .L(l1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1), .fail_flags(ff1)
    );

    always_comb begin
        if (sel == 0) begin
            o_busy = busy0; o_done = done0; o_pass = pass0; o_err = err0;
            o_fv = fv0; o_fa = fa0; o_fb = fb0; o_ff = ff0; o_a = a0; o_b = b0;
        end else begin
            o_busy = busy1; o_done = done1; o_pass = pass1; o_err = err1;
            o_fv = fv1; o_fa = fa1; o_fb = fb1; o_ff = ff1; o_a = a1; o_b = b1;
        end
    end

    function automatic exp_t predict(input int settle, input int md, input int nvec);
        exp_t r;
        logic [2:0] gold, obs;
        int a, b;
        r.cycles = (1 << (2 * W)) * (settle + 1);
        r.err = 0; r.fv = 1'b0; r.fa = 0; r.fb = 0; r.ff = 3'b000;
        for (int k = 0; k < nvec; k++) begin
            a    = k >> W;
            b    = k & ((1 << W) - 1);
            gold = {a == b, a > b, a < b};
            obs  = cmp_model(md, a, b);
            if (obs !== gold) begin
                r.err++;
                if (!r.fv) begin
                    r.fv = 1'b1; r.fa = a; r.fb = b; r.ff = obs;
                end
            end
        end
        r.pass = (r.err == 0);
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start_r = 1'b0; abort_r = 1'b0; sel = 0; mode = 0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({a0, b0, busy0, done0, pass0, err0, fv0, fa0, fb0, ff0} !== '0) begin
            n_fail++;
            $display("FAIL reset_dut0: got %h required 0", {a0, b0, busy0, done0, pass0, err0, fv0, fa0, fb0, ff0});
        end
        n_checks++;
        if ({a1, b1, busy1, done1, pass1, err1, fv1, fa1, fb1, ff1} !== '0) begin
            n_fail++;
            $display("FAIL reset_dut1: got %h required 0", {a1, b1, busy1, done1, pass1, err1, fv1, fa1, fb1, ff1});
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_sweep(input int s, input int settle, input int md,
                              input int restart_at, input logic with_abort, input string name);
        exp_t e;
        int   n, budget;
        sel  = s;
        mode = md;
        sb_q.push_back(predict(settle, md, 1 << (2 * W)));
        budget  = 2 * (1 << (2 * W)) * (settle + 1) + 10;
        start_r = 1'b1;
        abort_r = with_abort;
        @(posedge clk);
        #1;
        start_r = 1'b0;
        abort_r = 1'b0;
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_after_start: got %b required 1", name, o_busy);
        end
        n = 0;
        while (n < budget) begin
            start_r = (n == restart_at);
            @(posedge clk);
            #1;
            start_r = 1'b0;
            n++;
            if (o_done) break;
        end
        e = sb_q.pop_front();
        n_checks++;
        if (n != e.cycles) begin
            n_fail++;
            $display("FAIL %s done_latency: got %0d required %0d", name, n, e.cycles);
        end
        n_checks++;
        if (o_err !== CW'(e.err)) begin
            n_fail++;
            $display("FAIL %s err_cnt: got %0d required %0d", name, o_err, e.err);
        end
        n_checks++;
        if ({o_fv, o_pass, o_busy} !== {e.fv, e.pass, 1'b0}) begin
            n_fail++;
            $display("FAIL %s fv_pass_busy: got %b required %b", name, {o_fv, o_pass, o_busy}, {e.fv, e.pass, 1'b0});
        end
        if (e.fv) begin
            n_checks++;
            if ({o_fa, o_fb, o_ff} !== {W'(e.fa), W'(e.fb), e.ff}) begin
                n_fail++;
                $display("FAIL %s fail_record: got a=%h b=%h f=%b required a=%h b=%h f=%b",
                         name, o_fa, o_fb, o_ff, e.fa, e.fb, e.ff);
            end
        end
    endtask

    task automatic test_abort();
        exp_t e;
        sel  = 0;
        mode = 1;
        e = predict(1, 1, 100);
        start_r = 1'b1;
        @(posedge clk);
        #1;
        start_r = 1'b0;
        repeat (2 * 100 + 1) @(posedge clk);
        #1;
        n_checks++;
        if ({o_a, o_b, o_busy} !== {W'(6), W'(4), 1'b1}) begin
            n_fail++;
            $display("FAIL abort_pre: got a=%h b=%h busy=%b required a=6 b=4 busy=1", o_a, o_b, o_busy);
        end
        start_r = 1'b1;
        abort_r = 1'b1;
        @(posedge clk);
        #1;
        start_r = 1'b0;
        abort_r = 1'b0;
        n_checks++;
        if ({o_busy, o_done, o_pass, o_a, o_b} !== {3'b000, W'(6), W'(4)}) begin
            n_fail++;
            $display("FAIL abort_state: got busy=%b done=%b pass=%b a=%h b=%h required 0 0 0 6 4",
                     o_busy, o_done, o_pass, o_a, o_b);
        end
        n_checks++;
        if ({o_err, o_fv, o_fa, o_fb, o_ff} !== {CW'(e.err), e.fv, W'(e.fa), W'(e.fb), e.ff}) begin
            n_fail++;
            $display("FAIL abort_retain: got err=%0d fv=%b a=%h b=%h f=%b required err=%0d fv=%b a=%h b=%h f=%b",
                     o_err, o_fv, o_fa, o_fb, o_ff, e.err, e.fv, e.fa, e.fb, e.ff);
        end
        abort_r = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        abort_r = 1'b0;
        n_checks++;
        if ({o_busy, o_done, o_a, o_b, o_err} !== {2'b00, W'(6), W'(4), CW'(e.err)}) begin
            n_fail++;
            $display("FAIL abort_in_idle: got busy=%b done=%b a=%h b=%h err=%0d", o_busy, o_done, o_a, o_b, o_err);
        end
    endtask

    task automatic test_reset_mid();
        sel  = 0;
        mode = 1;
        start_r = 1'b1;
        @(posedge clk);
        #1;
        start_r = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_a, o_b, o_busy, o_done, o_err, o_fv} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got a=%h b=%h busy=%b done=%b err=%0d fv=%b required all 0",
                     o_a, o_b, o_busy, o_done, o_err, o_fv);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_sweep(0, 1, 0, -1, 1'b0, "w4s1_good");
        test_sweep(0, 1, 1, -1, 1'b0, "w4s1_swap_gl");
        test_sweep(0, 1, 2, -1, 1'b0, "w4s1_e_stuck0");
        test_abort();
        test_sweep(0, 1, 0, -1, 1'b1, "restart_after_abort");
        test_sweep(0, 1, 0, 20, 1'b0, "start_ignored");
        test_reset_mid();
        test_sweep(1, 3, 0, -1, 1'b0, "w4s3_good");
        test_sweep(1, 3, 3, -1, 1'b0, "w4s3_e_at_5_a");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
